// File: rtl/div_2c_seq.sv
// Sequential two's-complement divider: 2N-bit dividend / N-bit divisor using radix-2 restoring iteration on magnitudes.
// Optional macro DIV_EARLY_OUT_EN: PREP jumps straight to DONE on divide-by-zero, unsigned overflow or zero dividend.
module div_2c_seq #(
  parameter int unsigned N = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           dz
);
  localparam int unsigned ZW = 2 * N;
  localparam int unsigned CW = $clog2(N);
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINNEG = {1'b1, {(N-1){1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [ZW-1:0] z_q, z_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  ymag_q, ymag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sgnq_q, sgnq_d;
  logic          sgnr_q, sgnr_d;
  logic          dzf_q, dzf_d;
  logic          uovf_q, uovf_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic          zneg, yneg, yzero, uovf_c, sovf;
  logic [ZW-1:0] zabs;
  logic [N-1:0]  yabs, qneg, rneg;
  logic [N:0]    shifted, diff;

  // Operand magnitudes and flags, valid while in PREP (operands latched in IDLE)
  assign zneg    = z_q[ZW-1];
  assign yneg    = y_q[N-1];
  assign zabs    = zneg ? ZW'(~z_q + ZW'(1)) : z_q;
  assign yabs    = yneg ? N'(~y_q + N'(1)) : y_q;
  assign yzero   = (y_q == '0);
  assign uovf_c  = !yzero && (zabs[ZW-1:N] >= yabs);

  // |Y| <= 2^(N-1) keeps the N+1-bit trial difference sign-correct
  assign shifted = {rem_q, quo_q[N-1]};
  assign diff    = shifted - {1'b0, ymag_q};
  assign qneg    = N'(~quo_q + N'(1));
  assign rneg    = N'(~rem_q + N'(1));
  assign sovf    = sgnq_q ? (quo_q > MINNEG) : (quo_q > MAXPOS);

`ifdef DIV_EARLY_OUT_EN
  logic zzero;
  assign zzero = (z_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      z_q         <= '0;
      y_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      ymag_q      <= '0;
      cnt_q       <= '0;
      sgnq_q      <= 1'b0;
      sgnr_q      <= 1'b0;
      dzf_q       <= 1'b0;
      uovf_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      y_q         <= y_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      ymag_q      <= ymag_d;
      cnt_q       <= cnt_d;
      sgnq_q      <= sgnq_d;
      sgnr_q      <= sgnr_d;
      dzf_q       <= dzf_d;
      uovf_q      <= uovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    y_d         = y_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    ymag_d      = ymag_q;
    cnt_d       = cnt_q;
    sgnq_d      = sgnq_q;
    sgnr_d      = sgnr_q;
    dzf_d       = dzf_q;
    uovf_d      = uovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          z_d        = dividend;
          y_d        = divisor;
          in_ready_d = 1'b0;
          state_d    = S_PREP;
        end
      end
      S_PREP: begin
        rem_d   = zabs[ZW-1:N];
        quo_d   = zabs[N-1:0];
        ymag_d  = yabs;
        sgnq_d  = zneg ^ yneg;
        sgnr_d  = zneg;
        dzf_d   = yzero;
        uovf_d  = uovf_c;
        cnt_d   = '0;
        state_d = S_ITER;
`ifdef DIV_EARLY_OUT_EN
        if (yzero || uovf_c || zzero) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (yzero) begin
            quotient_d  = zneg ? MINNEG : MAXPOS;
            remainder_d = z_q[N-1:0];
            ovf_d       = 1'b0;
            dz_d        = 1'b1;
          end else if (uovf_c) begin
            quotient_d  = (zneg ^ yneg) ? MINNEG : MAXPOS;
            remainder_d = '0;
            ovf_d       = 1'b1;
            dz_d        = 1'b0;
          end else begin
            quotient_d  = '0;
            remainder_d = '0;
            ovf_d       = 1'b0;
            dz_d        = 1'b0;
          end
        end
`endif
      end
      S_ITER: begin
        if (!diff[N]) begin
          rem_d = diff[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        if (dzf_q) begin
          quotient_d  = sgnr_q ? MINNEG : MAXPOS;
          remainder_d = z_q[N-1:0];
          ovf_d       = 1'b0;
          dz_d        = 1'b1;
        end else if (uovf_q || sovf) begin
          quotient_d  = sgnq_q ? MINNEG : MAXPOS;
          remainder_d = '0;
          ovf_d       = 1'b1;
          dz_d        = 1'b0;
        end else begin
          quotient_d  = sgnq_q ? qneg : quo_q;
          remainder_d = sgnr_q ? rneg : rem_q;
          ovf_d       = 1'b0;
          dz_d        = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
